// File: rtl/conv_job_sequencer.sv
// rtl/conv_job_sequencer.sv - drives one ID1000500A_conv core: size/X/Y load, start, wait, result stream, ack
// Optional build macro CONV_SEQ_TIMEOUT_EN bounds the wait for core_int and routes expiry through ERR.
module conv_job_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int CONF_WIDTH = 5,
  parameter int SIZE_WIDTH = 5,
  parameter logic [CONF_WIDTH-1:0] CONF_MEMX = 5'd0,
  parameter logic [CONF_WIDTH-1:0] CONF_MEMY = 5'd1,
  parameter logic [CONF_WIDTH-1:0] CONF_SIZE = 5'd2,
  parameter logic [CONF_WIDTH-1:0] CONF_MEMZ = 5'd3,
  parameter logic [CONF_WIDTH-1:0] CONF_STAT = 5'd4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [SIZE_WIDTH-1:0] job_size_x,
  input  logic [SIZE_WIDTH-1:0] job_size_y,
  input  logic                  smp_valid,
  output logic                  smp_ready,
  input  logic [DATA_WIDTH-1:0] smp_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] core_data_in,
  input  logic [DATA_WIDTH-1:0] core_data_out,
  output logic                  core_write,
  output logic                  core_read,
  output logic                  core_start,
  output logic [CONF_WIDTH-1:0] core_conf,
  input  logic                  core_int
);

  localparam int CW = SIZE_WIDTH + 1;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_SIZE  = 4'd1;
  localparam logic [3:0] S_LDX   = 4'd2;
  localparam logic [3:0] S_LDY   = 4'd3;
  localparam logic [3:0] S_START = 4'd4;
  localparam logic [3:0] S_WAIT  = 4'd5;
  localparam logic [3:0] S_RDZ   = 4'd6;
  localparam logic [3:0] S_ACK   = 4'd7;
  localparam logic [3:0] S_ERR   = 4'd8;

  logic [3:0]            state;
  logic                  arm;
  logic [SIZE_WIDTH-1:0] size_x;
  logic [SIZE_WIDTH-1:0] size_y;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cap_cnt;
  logic [CW-1:0]         n_res;
  logic [CW-1:0]         phase_len;
  logic                  pend;
  logic                  smp_acc;
  logic                  last_smp;
  logic                  cap;
  logic                  drain;
  logic                  job_zero;
`ifdef CONV_SEQ_TIMEOUT_EN
  logic [15:0]           tmo;
`endif

  // arm is low for the first cycle of each phase so core_conf settles before any access
  assign n_res     = CW'(size_x) + CW'(size_y) - CW'(1);
  assign phase_len = (state == S_LDY) ? CW'(size_y) : CW'(size_x);
  assign job_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign smp_ready = arm && ((state == S_LDX) || (state == S_LDY)) && (cnt < phase_len);
  assign smp_acc   = smp_valid && smp_ready;
  assign last_smp  = smp_acc && ((cnt + CW'(1)) == phase_len);
  assign drain     = res_valid && res_ready;
  assign cap       = pend && (!res_valid || res_ready);
  assign core_read = (state == S_RDZ) && arm && (cnt < n_res) && (!res_valid || res_ready);
  assign core_start = (state == S_START);
  assign done      = drain && res_last;
  assign job_zero  = (job_size_x == '0) || (job_size_y == '0);

  always_comb begin
    core_write   = 1'b0;
    core_data_in = '0;
    case (state)
      S_SIZE: begin
        core_write   = arm;
        core_data_in = arm ? DATA_WIDTH'({size_y, size_x}) : '0;
      end
      S_LDX, S_LDY: begin
        core_write   = smp_acc;
        core_data_in = smp_data;
      end
      S_ACK, S_ERR: core_write = arm;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      arm       <= 1'b0;
      size_x    <= '0;
      size_y    <= '0;
      cnt       <= '0;
      cap_cnt   <= '0;
      pend      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_last  <= 1'b0;
      err       <= 1'b0;
      core_conf <= CONF_STAT;
`ifdef CONV_SEQ_TIMEOUT_EN
      tmo       <= '0;
`endif
    end else begin
      arm <= 1'b1;
      case (state)
        S_IDLE: begin
          if (job_valid) begin
            size_x <= job_size_x;
            size_y <= job_size_y;
            err    <= job_zero;
            if (!job_zero) begin
              state     <= S_SIZE;
              core_conf <= CONF_SIZE;
              arm       <= 1'b0;
            end
          end
        end
        S_SIZE: begin
          if (arm) begin
            state     <= S_LDX;
            core_conf <= CONF_MEMX;
            arm       <= 1'b0;
            cnt       <= '0;
          end
        end
        S_LDX, S_LDY: begin
          if (smp_acc) cnt <= cnt + CW'(1);
          if (last_smp) begin
            cnt <= '0;
            if (state == S_LDX) begin
              state     <= S_LDY;
              core_conf <= CONF_MEMY;
              arm       <= 1'b0;
            end else begin
              state <= S_START;
            end
          end
        end
        S_START: begin
          state <= S_WAIT;
`ifdef CONV_SEQ_TIMEOUT_EN
          tmo   <= '0;
`endif
        end
        S_WAIT: begin
          if (core_int) begin
            state     <= S_RDZ;
            core_conf <= CONF_MEMZ;
            arm       <= 1'b0;
            cnt       <= '0;
            cap_cnt   <= '0;
            pend      <= 1'b0;
          end
`ifdef CONV_SEQ_TIMEOUT_EN
          else if (tmo == 16'hFFFE) begin
            state     <= S_ERR;
            core_conf <= CONF_STAT;
            arm       <= 1'b0;
            err       <= 1'b1;
          end else begin
            tmo <= tmo + 16'd1;
          end
`endif
        end
        S_RDZ: begin
          // core_data_out holds until the next read, so an uncaptured word simply waits in pend
          if (core_read) cnt <= cnt + CW'(1);
          pend <= core_read || (pend && !cap);
          if (cap) begin
            res_valid <= 1'b1;
            res_data  <= core_data_out;
            res_last  <= (cap_cnt == (n_res - CW'(1)));
            cap_cnt   <= cap_cnt + CW'(1);
          end else if (drain) begin
            res_valid <= 1'b0;
            res_last  <= 1'b0;
          end
          if (done) begin
            state     <= S_ACK;
            core_conf <= CONF_STAT;
            arm       <= 1'b0;
          end
        end
        S_ACK, S_ERR: begin
          if (arm) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
